// File: rtl/counter_split_pkg.sv
// Shared types and constants for the counter split stream and its helpers.
package counter_split_pkg;

  // Small-part rule applied to large counters.
  localparam int MODE_ZERO  = 0;  // small part is 0, large path carries full value
  localparam int MODE_CLAMP = 1;  // small part is thr, large path carries c - thr

  // Default geometry of the sketch readout.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_IDX_W = 16;

  // Canonical large-entry layout at default geometry. Parametrised users
  // rebuild the same field order locally and size it with large_entry_w.
  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_WIDTH-1:0] value;
    logic                 last;
  } large_entry_t;

  function automatic int large_entry_w(input int idx_w, input int width);
    return idx_w + width + 1;
  endfunction

  // Frame tracking state.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  // Observation struct for checkers.
  typedef struct packed {
    frame_state_e state;
    logic         fifo_full;
  } dbg_t;

endpackage

// File: rtl/counter_split_stream_fifo.sv
// First-word-fall-through synchronous FIFO; power-of-two depth, occupancy exposed.
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Wr_En,
  input  logic [W-1:0]  Wr_Data,
  input  logic          Rd_En,
  output logic [W-1:0]  Rd_Data,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign Empty   = (cnt == '0);
  assign Full    = (cnt == (AW+1)'(DEPTH));
  assign Count   = cnt;
  assign Rd_Data = mem[rd_ptr];
  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop     = Rd_En && !Empty;
  assign push    = Wr_En && (!Full || pop);

  // Storage array; contents need no reset because Empty masks stale words.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= Wr_Data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/counter_split_stream.sv
// Splits a counter stream into a dense small stream and a buffered sparse
// (index, value) stream of counters above a per-frame threshold.
//
// Handshakes: every stream transfers a beat on a rising Clk edge where
// Valid && Ready; Valid never waits on Ready, and a presented beat keeps its
// data unchanged until it is taken.
module counter_split_stream
  import counter_split_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int IDX_W       = 16,
  parameter int LARGE_DEPTH = 16,
  parameter int MODE        = MODE_ZERO
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Thr_Cfg,
  input  logic             Cnt_Valid,
  output logic             Cnt_Ready,
  input  logic [WIDTH-1:0] Cnt_Data,
  input  logic             Cnt_Last,
  output logic             Small_Valid,
  input  logic             Small_Ready,
  output logic [WIDTH-1:0] Small_Data,
  output logic             Small_Last,
  output logic             Large_Valid,
  input  logic             Large_Ready,
  output logic [IDX_W-1:0] Large_Index,
  output logic [WIDTH-1:0] Large_Value,
  output logic             Large_Last,
  output logic             Frame_Done,
  output logic [IDX_W:0]   Large_Count,
  output dbg_t             Dbg
);

  localparam int AW = $clog2(LARGE_DEPTH);
  localparam int EW = large_entry_w(IDX_W, WIDTH);
  localparam logic [AW:0] FIFO_CAP = (AW+1)'(LARGE_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] value;
    logic             last;
  } entry_t;

  frame_state_e     state_q, state_d;
  logic [WIDTH-1:0] thr_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_en_q;
  logic             small_valid_q;
  logic [WIDTH-1:0] small_data_q;
  logic             small_last_q;
  logic [IDX_W:0]   frame_cnt_q;
  logic [IDX_W:0]   large_count_q;
  logic             frame_done_q;

  logic             accept;
  logic [WIDTH-1:0] cur_thr;
  logic             is_large;
  logic [WIDTH-1:0] small_val;
  logic [WIDTH-1:0] large_val;
  logic [IDX_W:0]   large_inc;
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [EW-1:0]    rd_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  // Input is taken only when the small register can move and the FIFO has room;
  // ready_en_q keeps the port closed through the reset cycle.
  assign Cnt_Ready = ready_en_q && (!small_valid_q || Small_Ready) && (fifo_count < FIFO_CAP);
  assign accept    = Cnt_Valid && Cnt_Ready;

  // The first beat of a frame uses the live threshold; later beats use the latched one.
  assign cur_thr   = (state_q == IDLE) ? Thr_Cfg : thr_q;
  assign is_large  = (Cnt_Data > cur_thr);
  assign small_val = is_large ? ((MODE == MODE_CLAMP) ? cur_thr : '0) : Cnt_Data;
  // In clamp mode c > thr always holds here, so the residue cannot underflow.
  assign large_val = (MODE == MODE_CLAMP) ? (Cnt_Data - cur_thr) : Cnt_Data;
  assign large_inc = {{IDX_W{1'b0}}, is_large};

  assign wr_entry.idx   = idx_q;
  assign wr_entry.value = large_val;
  assign wr_entry.last  = Cnt_Last;

  sync_fifo_fwft #(
    .W     (EW),
    .DEPTH (LARGE_DEPTH)
  ) u_large_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .Wr_En   (accept && is_large),
    .Wr_Data (wr_entry),
    .Rd_En   (Large_Ready),
    .Rd_Data (rd_raw),
    .Full    (fifo_full),
    .Empty   (fifo_empty),
    .Count   (fifo_count)
  );

  assign rd_entry    = rd_raw;
  assign Large_Valid = !fifo_empty;
  assign Large_Index = fifo_empty ? '0 : rd_entry.idx;
  assign Large_Value = fifo_empty ? '0 : rd_entry.value;
  assign Large_Last  = fifo_empty ? 1'b0 : rd_entry.last;

  assign Small_Valid = small_valid_q;
  assign Small_Data  = small_data_q;
  assign Small_Last  = small_last_q;
  assign Frame_Done  = frame_done_q;
  assign Large_Count = large_count_q;

  assign Dbg.state     = state_q;
  assign Dbg.fifo_full = fifo_full;

  // Frame FSM next state: a Last beat always closes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && !Cnt_Last) state_d = IN_FRAME;
      IN_FRAME: if (accept && Cnt_Last)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Frame state, threshold latch and in-frame index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      idx_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept && (state_q == IDLE)) thr_q <= Thr_Cfg;
      // Index is back at 0 whenever the FSM is idle; it wraps silently on overlong frames.
      if (accept) idx_q <= Cnt_Last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Dense small-part output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      small_valid_q <= 1'b0;
      small_data_q  <= '0;
      small_last_q  <= 1'b0;
    end else if (accept) begin
      small_valid_q <= 1'b1;
      small_data_q  <= small_val;
      small_last_q  <= Cnt_Last;
    end else if (Small_Ready) begin
      small_valid_q <= 1'b0;
    end
  end

  // Per-frame large-entry statistics and end-of-frame pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt_q   <= '0;
      large_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= accept && Cnt_Last;
      if (accept) begin
        if (Cnt_Last) begin
          large_count_q <= frame_cnt_q + large_inc;
          frame_cnt_q   <= '0;
        end else begin
          frame_cnt_q   <= frame_cnt_q + large_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_split_stream.sv
// Scoreboard bench: instance A (MODE 0) carries most scenarios, instance B (MODE 1)
// repeats the basic frame with the clamp rule. Both use a 4-entry large FIFO.
module tb_counter_split_stream;
  import counter_split_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] thr_cfg  = '0;
  logic [31:0] cnt_data = '0;
  logic        cnt_last = 1'b0;
  logic        a_valid  = 1'b0;
  logic        b_valid  = 1'b0;
  logic        small_ready = 1'b1;
  logic        large_ready = 1'b1;

  // ---------------- instance A outputs ----------------
  logic        a_cnt_ready, a_small_valid, a_small_last, a_large_valid, a_large_last, a_frame_done;
  logic [31:0] a_small_data, a_large_value;
  logic [15:0] a_large_index;
  logic [16:0] a_large_count;
  dbg_t        a_dbg;

  // ---------------- instance B outputs ----------------
  logic        b_cnt_ready, b_small_valid, b_small_last, b_large_valid, b_large_last, b_frame_done;
  logic [31:0] b_small_data, b_large_value;
  logic [15:0] b_large_index;
  logic [16:0] b_large_count;
  dbg_t        b_dbg;

  counter_split_stream #(.WIDTH(32), .IDX_W(16), .LARGE_DEPTH(4), .MODE(MODE_ZERO)) u_a (
    .Clk(clk), .Reset(rst), .Thr_Cfg(thr_cfg),
    .Cnt_Valid(a_valid), .Cnt_Ready(a_cnt_ready), .Cnt_Data(cnt_data), .Cnt_Last(cnt_last),
    .Small_Valid(a_small_valid), .Small_Ready(small_ready), .Small_Data(a_small_data), .Small_Last(a_small_last),
    .Large_Valid(a_large_valid), .Large_Ready(large_ready), .Large_Index(a_large_index),
    .Large_Value(a_large_value), .Large_Last(a_large_last),
    .Frame_Done(a_frame_done), .Large_Count(a_large_count), .Dbg(a_dbg)
  );

  counter_split_stream #(.WIDTH(32), .IDX_W(16), .LARGE_DEPTH(4), .MODE(MODE_CLAMP)) u_b (
    .Clk(clk), .Reset(rst), .Thr_Cfg(thr_cfg),
    .Cnt_Valid(b_valid), .Cnt_Ready(b_cnt_ready), .Cnt_Data(cnt_data), .Cnt_Last(cnt_last),
    .Small_Valid(b_small_valid), .Small_Ready(1'b1), .Small_Data(b_small_data), .Small_Last(b_small_last),
    .Large_Valid(b_large_valid), .Large_Ready(1'b1), .Large_Index(b_large_index),
    .Large_Value(b_large_value), .Large_Last(b_large_last),
    .Frame_Done(b_frame_done), .Large_Count(b_large_count), .Dbg(b_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] a_small_q[$], b_small_q[$];  // {last, data}
  logic [48:0] a_large_q[$], b_large_q[$];  // {last, idx, value}
  logic [16:0] a_fd_q[$],    b_fd_q[$];     // Large_Count at Frame_Done
  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mon_en    = 1'b1;
  int a_acc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic extra(input string name, input logic [63:0] act);
    total_cnt++;
    $display("FAIL %s_extra: got unexpected output %0h expected none", name, act);
  endtask

  task automatic exp_small(input bit b, input logic [31:0] d, input logic l);
    if (b) b_small_q.push_back({l, d}); else a_small_q.push_back({l, d});
  endtask

  task automatic exp_large(input bit b, input logic [15:0] i, input logic [31:0] v, input logic l);
    if (b) b_large_q.push_back({l, i, v}); else a_large_q.push_back({l, i, v});
  endtask

  task automatic exp_fd(input bit b, input logic [16:0] c);
    if (b) b_fd_q.push_back(c); else a_fd_q.push_back(c);
  endtask

  // ---------------- monitors ----------------
  logic        a_stall = 1'b0;
  logic [32:0] a_held  = '0;

  // Instance A: pops expectations whenever a stream transfers.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) check("a_small_hold", {a_small_valid, a_small_last, a_small_data}, {1'b1, a_held});
      a_stall = a_small_valid && !small_ready;
      a_held  = {a_small_last, a_small_data};
      if (a_small_valid && small_ready) begin
        if (a_small_q.size() == 0) extra("a_small", {a_small_last, a_small_data});
        else check("a_small", {a_small_last, a_small_data}, a_small_q.pop_front());
      end
      if (a_large_valid && large_ready) begin
        if (a_large_q.size() == 0) extra("a_large", {a_large_last, a_large_index, a_large_value});
        else check("a_large", {a_large_last, a_large_index, a_large_value}, a_large_q.pop_front());
      end
    end
    if (!rst && a_frame_done) begin
      if (a_fd_q.size() == 0) extra("a_frame_done", a_large_count);
      else check("a_large_count", a_large_count, a_fd_q.pop_front());
    end
    if (a_valid && a_cnt_ready) a_acc++;
  end

  // Instance B: sinks always ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_small_valid) begin
        if (b_small_q.size() == 0) extra("b_small", {b_small_last, b_small_data});
        else check("b_small", {b_small_last, b_small_data}, b_small_q.pop_front());
      end
      if (b_large_valid) begin
        if (b_large_q.size() == 0) extra("b_large", {b_large_last, b_large_index, b_large_value});
        else check("b_large", {b_large_last, b_large_index, b_large_value}, b_large_q.pop_front());
      end
      if (b_frame_done) begin
        if (b_fd_q.size() == 0) extra("b_frame_done", b_large_count);
        else check("b_large_count", b_large_count, b_fd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    cnt_data = d;
    cnt_last = l;
    if (b) b_valid = 1'b1; else a_valid = 1'b1;
    @(negedge clk);
    while (!(b ? b_cnt_ready : a_cnt_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(b ? b_cnt_ready : a_cnt_ready)) begin
      total_cnt++;
      $display("FAIL send_timeout: ready got 0 for data %0d expected 1", d);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    int left;
    n = 0;
    left = a_small_q.size() + a_large_q.size() + a_fd_q.size() +
           b_small_q.size() + b_large_q.size() + b_fd_q.size();
    while (left != 0 && n < 500) begin
      tick();
      n++;
      left = a_small_q.size() + a_large_q.size() + a_fd_q.size() +
             b_small_q.size() + b_large_q.size() + b_fd_q.size();
    end
    repeat (3) tick();
    check(name, left, 0);
  endtask

  // ---------------- stimulus ----------------
  bit t3_done = 1'b0;
  bit t4_run  = 1'b0;

  initial begin
    int fd_cnt;
    int gap;
    logic [31:0] d;

    // Reset state, sampled while Reset is still asserted.
    repeat (3) tick();
    check("rst_cnt_ready", a_cnt_ready, 0);
    check("rst_small_valid", a_small_valid, 0);
    check("rst_large_valid", a_large_valid, 0);
    check("rst_large_count", a_large_count, 0);
    check("rst_small_data", a_small_data, 0);
    check("rst_state", a_dbg.state, IDLE);
    rst = 1'b0;

    // MODE 0 basic frame, thr=20.
    thr_cfg = 20;
    exp_small(0, 5, 0);  exp_small(0, 20, 0); exp_small(0, 0, 0);
    exp_small(0, 0, 0);  exp_small(0, 0, 1);
    exp_large(0, 2, 21, 0); exp_large(0, 4, 100, 1);
    exp_fd(0, 2);
    send(0, 5, 0); send(0, 20, 0); send(0, 21, 0); send(0, 0, 0); send(0, 100, 1);
    drain("t1_drain");

    // MODE 1 basic frame, thr=20.
    exp_small(1, 5, 0);  exp_small(1, 20, 0); exp_small(1, 20, 0);
    exp_small(1, 0, 0);  exp_small(1, 20, 1);
    exp_large(1, 2, 1, 0); exp_large(1, 4, 80, 1);
    exp_fd(1, 2);
    send(1, 5, 0); send(1, 20, 0); send(1, 21, 0); send(1, 0, 0); send(1, 100, 1);
    drain("t2_drain");

    // Large backpressure fills the FIFO, thr=0, eight beats of 7.
    thr_cfg = 0;
    large_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_small(0, 0, i == 7);
      exp_large(0, 16'(i), 7, i == 7);
    end
    exp_fd(0, 8);
    gap = a_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 7, i == 7);
        t3_done = 1'b1;
      end
    join_none
    repeat (20) tick();
    check("t3_accepts", a_acc - gap, 4);
    check("t3_ready_held", a_cnt_ready, 0);
    check("t3_fifo_full", a_dbg.fifo_full, 1);
    large_ready = 1'b1;
    for (int k = 0; k < 400 && !t3_done; k++) tick();
    check("t3_sender_done", t3_done, 1);
    drain("t3_drain");

    // Small_Ready toggling with random input gaps, 1000-beat frame, thr=20.
    thr_cfg = 20;
    fd_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      d = 32'((i * 7) % 41);
      exp_small(0, (d > 20) ? 32'd0 : d, i == 999);
      if (d > 20) begin
        exp_large(0, 16'(i), d, i == 999);
        fd_cnt++;
      end
    end
    exp_fd(0, 17'(fd_cnt));
    t4_run = 1'b1;
    fork
      begin
        while (t4_run) begin
          @(posedge clk);
          #1;
          small_ready = ~small_ready;
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      send(0, 32'((i * 7) % 41), i == 999);
    end
    t4_run = 1'b0;
    repeat (2) tick();
    small_ready = 1'b1;
    drain("t4_drain");

    // Threshold changed mid-frame is ignored until the next frame.
    thr_cfg = 20;
    exp_small(0, 10, 0); exp_small(0, 10, 0); exp_small(0, 10, 1);
    exp_fd(0, 0);
    send(0, 10, 0);
    thr_cfg = 5;
    send(0, 10, 0);
    send(0, 10, 1);
    exp_small(0, 0, 1);
    exp_large(0, 0, 10, 1);
    exp_fd(0, 1);
    send(0, 10, 1);
    drain("t5_drain");

    // Reset in the middle of a frame with two large entries buffered.
    mon_en = 1'b0;
    large_ready = 1'b0;
    thr_cfg = 20;
    send(0, 25, 0); send(0, 5, 0); send(0, 30, 0);
    check("t6_state_in_frame", a_dbg.state, IN_FRAME);
    check("t6_large_buffered", a_large_valid, 1);
    rst = 1'b1;
    tick();
    check("t6_small_valid", a_small_valid, 0);
    check("t6_large_valid", a_large_valid, 0);
    check("t6_cnt_ready", a_cnt_ready, 0);
    check("t6_large_count", a_large_count, 0);
    check("t6_large_index", a_large_index, 0);
    check("t6_state", a_dbg.state, IDLE);
    rst = 1'b0;
    large_ready = 1'b1;
    mon_en = 1'b1;
    tick();
    check("t6_ready_back", a_cnt_ready, 1);
    check("t6_fifo_empty", a_large_valid, 0);
    exp_small(0, 0, 1);
    exp_large(0, 0, 30, 1);
    exp_fd(0, 1);
    send(0, 30, 1);
    drain("t6_drain");

    check("end_a_state", a_dbg.state, IDLE);
    check("end_b_state", b_dbg.state, IDLE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
